// File: rtl/rotary_step_ctrl_if.sv
// Rotary controller port bundle: button levels in, rotary position out.
// Latency: none (wires only).
// Backpressure: none; cw/ccw are levels and the outputs are always valid.
//   cw, ccw   : button request levels, active-high, synchronous to clk_sys
//   rotary    : one-hot position, bit[pos] set
//   pos       : binary position index
//   step      : one-cycle strobe per position change
//   step_dir  : direction of the last step (1 = ccw, 0 = cw)
interface rotary_step_ctrl_if #(
    parameter int POSITIONS = 12
);
    localparam int PW = (POSITIONS > 2) ? $clog2(POSITIONS) : 1;

    logic                 cw;
    logic                 ccw;
    logic [POSITIONS-1:0] rotary;
    logic [PW-1:0]        pos;
    logic                 step;
    logic                 step_dir;

    // master: button source (arcade_inputs side)
    modport master (
        output cw, ccw,
        input  rotary, pos, step, step_dir
    );

    // slave: the rotary controller itself
    modport slave (
        input  cw, ccw,
        output rotary, pos, step, step_dir
    );
endinterface

// File: rtl/rotary_step_ctrl.sv
// Rotary position controller: cw/ccw levels -> wrapping N-position rotary with hold-to-repeat.
// Latency: 1 cycle from a qualifying request to pos/rotary/step/step_dir.
// Backpressure: none; requests are levels, every step is a one-cycle strobe.
// Ports: clk_sys, reset (sync, active-high), io (rotary_step_ctrl_if.slave).
// Optional macro ROTARY_ACCEL_EN: after ACCEL_AFTER repeat steps the repeat
// period shrinks to REPEAT_CYC/4 until release or direction change.
module rotary_step_ctrl #(
    parameter int POSITIONS   = 12,
    parameter int RESET_POS   = 0,
    parameter int DELAY_CYC   = 21600000,
    parameter int REPEAT_CYC  = 4320000,
    parameter int ACCEL_AFTER = 8
) (
    input  logic               clk_sys,
    input  logic               reset,
    rotary_step_ctrl_if.slave  io
);
    localparam int PW   = (POSITIONS > 2) ? $clog2(POSITIONS) : 1;
    localparam int CMAX = (DELAY_CYC > REPEAT_CYC) ? DELAY_CYC : REPEAT_CYC;
    localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0]        DELAY_LOAD  = CW'(DELAY_CYC - 1);
    localparam logic [CW-1:0]        REPEAT_LOAD = CW'(REPEAT_CYC - 1);
    localparam logic [PW-1:0]        POS_MAX     = PW'(POSITIONS - 1);
    localparam logic [PW-1:0]        POS_RST     = PW'(RESET_POS);
    localparam logic [POSITIONS-1:0] ROT_RST     = {{(POSITIONS-1){1'b0}}, 1'b1} << RESET_POS;

`ifdef ROTARY_ACCEL_EN
    localparam int RCW = (ACCEL_AFTER > 1) ? $clog2(ACCEL_AFTER + 1) : 1;
    localparam logic [RCW-1:0] RC_SAT    = RCW'(ACCEL_AFTER);
    localparam logic [CW-1:0]  FAST_LOAD = ((REPEAT_CYC >> 2) > 0) ? CW'((REPEAT_CYC >> 2) - 1) : '0;
    logic [RCW-1:0] rc_q, rc_d, rc_inc;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 held_dir_q, held_dir_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic [POSITIONS-1:0] rotary_q, rotary_d;
    logic                 step_q, step_d;
    logic                 step_dir_q, step_dir_d;

    logic req;
    logic dir;
    logic do_step;

    // Both buttons pressed cancels out to "no request".
    assign req = io.cw ^ io.ccw;
    assign dir = io.ccw;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        held_dir_d = held_dir_q;
        do_step    = 1'b0;
`ifdef ROTARY_ACCEL_EN
        rc_d       = rc_q;
        rc_inc     = (rc_q == RC_SAT) ? rc_q : rc_q + RCW'(1);
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef ROTARY_ACCEL_EN
                rc_d = '0;
`endif
                if (req) begin
                    do_step    = 1'b1;
                    cnt_d      = DELAY_LOAD;
                    held_dir_d = dir;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!req) begin
                    state_d = ST_IDLE;
`ifdef ROTARY_ACCEL_EN
                    rc_d    = '0;
`endif
                end else if (dir != held_dir_q) begin
                    // Reversal behaves like a fresh press in the new direction.
                    do_step    = 1'b1;
                    cnt_d      = DELAY_LOAD;
                    held_dir_d = dir;
                    state_d    = ST_HOLD;
`ifdef ROTARY_ACCEL_EN
                    rc_d       = '0;
`endif
                end else if (cnt_q == '0) begin
                    do_step = 1'b1;
                    state_d = ST_REPEAT;
                    cnt_d   = REPEAT_LOAD;
`ifdef ROTARY_ACCEL_EN
                    // Only repeat-state steps count towards acceleration; the
                    // reload already uses the updated count.
                    if (state_q == ST_REPEAT) begin
                        rc_d  = rc_inc;
                        cnt_d = (rc_inc == RC_SAT) ? FAST_LOAD : REPEAT_LOAD;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Step datapath: dir is the stepping direction whenever do_step is set.
    always_comb begin
        pos_d      = pos_q;
        rotary_d   = rotary_q;
        step_d     = do_step;
        step_dir_d = step_dir_q;
        if (do_step) begin
            step_dir_d = dir;
            if (dir) begin
                pos_d    = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
                rotary_d = {rotary_q[POSITIONS-2:0], rotary_q[POSITIONS-1]};
            end else begin
                pos_d    = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
                rotary_d = {rotary_q[0], rotary_q[POSITIONS-1:1]};
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            held_dir_q <= 1'b0;
            pos_q      <= POS_RST;
            rotary_q   <= ROT_RST;
            step_q     <= 1'b0;
            step_dir_q <= 1'b0;
`ifdef ROTARY_ACCEL_EN
            rc_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            held_dir_q <= held_dir_d;
            pos_q      <= pos_d;
            rotary_q   <= rotary_d;
            step_q     <= step_d;
            step_dir_q <= step_dir_d;
`ifdef ROTARY_ACCEL_EN
            rc_q       <= rc_d;
`endif
        end
    end

    assign io.pos      = pos_q;
    assign io.rotary   = rotary_q;
    assign io.step     = step_q;
    assign io.step_dir = step_dir_q;

endmodule

// File: tb/tb_rotary_step_ctrl.sv
// Directed bench for rotary_step_ctrl with a 12-position, fast-timing configuration.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_rotary_step_ctrl;
    localparam int N = 12;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    rotary_step_ctrl_if #(.POSITIONS(N)) io ();

    rotary_step_ctrl #(
        .POSITIONS  (N),
        .RESET_POS  (0),
        .DELAY_CYC  (10),
        .REPEAT_CYC (4),
        .ACCEL_AFTER(2)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .io     (io)
    );

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; io.cw = 1'b0; io.ccw = 1'b0;
        cyc(); cyc();
        n_tests++; if (io.pos !== 4'd0) begin n_fail++; $display("FAIL reset_pos: got %0d expected 0", io.pos); end
        n_tests++; if (io.rotary !== 12'h001) begin n_fail++; $display("FAIL reset_rotary: got %h expected 001", io.rotary); end
        n_tests++; if (io.step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b expected 0", io.step); end
        n_tests++; if (io.step_dir !== 1'b0) begin n_fail++; $display("FAIL reset_step_dir: got %b expected 0", io.step_dir); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++; if (io.step !== 1'b0) begin n_fail++; $display("FAIL idle_step c%0d: got %b expected 0", i, io.step); end
        end
    endtask

    // pos 0 -> 11
    task automatic test_single_cw();
        io.cw = 1'b1; cyc(); io.cw = 1'b0;
        n_tests++; if (io.rotary !== 12'h800) begin n_fail++; $display("FAIL cw_rotary: got %h expected 800", io.rotary); end
        n_tests++; if (io.pos !== 4'd11) begin n_fail++; $display("FAIL cw_pos: got %0d expected 11", io.pos); end
        n_tests++; if (io.step !== 1'b1) begin n_fail++; $display("FAIL cw_step: got %b expected 1", io.step); end
        n_tests++; if (io.step_dir !== 1'b0) begin n_fail++; $display("FAIL cw_step_dir: got %b expected 0", io.step_dir); end
        for (int i = 0; i < 15; i++) begin
            cyc();
            n_tests++; if (io.step !== 1'b0 || io.pos !== 4'd11) begin
                n_fail++; $display("FAIL cw_after c%0d: got step=%b pos=%0d expected step=0 pos=11", i, io.step, io.pos);
            end
        end
    endtask

    // pos 11 -> 0 -> 1 -> 0
    task automatic test_ccw_pulse();
        io.ccw = 1'b1; cyc(); io.ccw = 1'b0;
        n_tests++; if (io.pos !== 4'd0 || io.rotary !== 12'h001) begin
            n_fail++; $display("FAIL ccw_wrap: got pos=%0d rotary=%h expected pos=0 rotary=001", io.pos, io.rotary);
        end
        n_tests++; if (io.step !== 1'b1 || io.step_dir !== 1'b1) begin
            n_fail++; $display("FAIL ccw_wrap_strobe: got step=%b dir=%b expected step=1 dir=1", io.step, io.step_dir);
        end
        cyc();
        io.ccw = 1'b1; cyc(); io.ccw = 1'b0;
        n_tests++; if (io.pos !== 4'd1 || io.rotary !== 12'h002) begin
            n_fail++; $display("FAIL ccw_second: got pos=%0d rotary=%h expected pos=1 rotary=002", io.pos, io.rotary);
        end
        cyc();
        io.cw = 1'b1; cyc(); io.cw = 1'b0;
        n_tests++; if (io.pos !== 4'd0 || io.rotary !== 12'h001) begin
            n_fail++; $display("FAIL cw_back: got pos=%0d rotary=%h expected pos=0 rotary=001", io.pos, io.rotary);
        end
        cyc();
    endtask

    // pos 0 -> 6: strobes at relative cycles 0,10,14,18,22,26
    task automatic test_hold_repeat();
        logic exp_step;
        int   n_steps = 0;
        io.cw = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            exp_step = (i == 0) || (i >= 10 && ((i - 10) % 4) == 0);
            if (io.step === 1'b1) n_steps++;
            n_tests++; if (io.step !== exp_step) begin
                n_fail++; $display("FAIL hold_step c%0d: got %b expected %b", i, io.step, exp_step);
            end
        end
        io.cw = 1'b0;
        cyc();
        n_tests++; if (n_steps != 6) begin n_fail++; $display("FAIL hold_count: got %0d expected 6", n_steps); end
        n_tests++; if (io.pos !== 4'd6 || io.rotary !== 12'h040) begin
            n_fail++; $display("FAIL hold_final: got pos=%0d rotary=%h expected pos=6 rotary=040", io.pos, io.rotary);
        end
        cyc();
    endtask

    // pos 6 -> 5 -> (both) -> 6
    task automatic test_both_pressed();
        io.cw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++; if (io.step !== (i == 0)) begin n_fail++; $display("FAIL both_pre c%0d: got %b", i, io.step); end
        end
        io.ccw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_tests++; if (io.step !== 1'b0 || io.pos !== 4'd5) begin
                n_fail++; $display("FAIL both_held c%0d: got step=%b pos=%0d expected step=0 pos=5", i, io.step, io.pos);
            end
        end
        io.cw = 1'b0;
        cyc();
        n_tests++; if (io.step !== 1'b1 || io.step_dir !== 1'b1 || io.pos !== 4'd6) begin
            n_fail++; $display("FAIL both_release: got step=%b dir=%b pos=%0d expected 1 1 6", io.step, io.step_dir, io.pos);
        end
        io.ccw = 1'b0;
        cyc(); cyc();
    endtask

    // pos 6 -> 5, reverse -> 6, repeat after delay -> 7
    task automatic test_dir_change();
        io.cw = 1'b1; cyc(); cyc(); cyc();
        n_tests++; if (io.pos !== 4'd5) begin n_fail++; $display("FAIL rev_pre: got %0d expected 5", io.pos); end
        io.cw = 1'b0; io.ccw = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            cyc();
            n_tests++; if (io.step !== (i == 0 || i == 10)) begin
                n_fail++; $display("FAIL rev_step c%0d: got %b", i, io.step);
            end
            if (i == 0) begin
                n_tests++; if (io.step_dir !== 1'b1 || io.pos !== 4'd6) begin
                    n_fail++; $display("FAIL rev_first: got dir=%b pos=%0d expected dir=1 pos=6", io.step_dir, io.pos);
                end
            end
        end
        io.ccw = 1'b0;
        cyc();
        n_tests++; if (io.pos !== 4'd7 || io.step !== 1'b0) begin
            n_fail++; $display("FAIL rev_final: got pos=%0d step=%b expected pos=7 step=0", io.pos, io.step);
        end
    endtask

    // pos 7 -> 5, reset -> 0, re-press -> 11, one delayed repeat -> 10
    task automatic test_reset_mid_hold();
        io.cw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            n_tests++; if (io.step !== (i == 0 || i == 10)) begin n_fail++; $display("FAIL rmh_pre c%0d: got %b", i, io.step); end
        end
        n_tests++; if (io.pos !== 4'd5) begin n_fail++; $display("FAIL rmh_pre_pos: got %0d expected 5", io.pos); end
        reset = 1'b1;
        cyc();
        n_tests++; if (io.pos !== 4'd0 || io.rotary !== 12'h001 || io.step !== 1'b0 || io.step_dir !== 1'b0) begin
            n_fail++; $display("FAIL rmh_in_reset: got pos=%0d rotary=%h step=%b dir=%b expected 0 001 0 0",
                               io.pos, io.rotary, io.step, io.step_dir);
        end
        reset = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            cyc();
            n_tests++; if (io.step !== (i == 0 || i == 10)) begin n_fail++; $display("FAIL rmh_post c%0d: got %b", i, io.step); end
            if (i == 0) begin
                n_tests++; if (io.pos !== 4'd11 || io.rotary !== 12'h800) begin
                    n_fail++; $display("FAIL rmh_first: got pos=%0d rotary=%h expected 11 800", io.pos, io.rotary);
                end
            end
        end
        io.cw = 1'b0;
        cyc();
        n_tests++; if (io.pos !== 4'd10) begin n_fail++; $display("FAIL rmh_final: got %0d expected 10", io.pos); end
    endtask

    // Long hold from pos 0: every 4 cycles by default, every cycle after 18 with acceleration.
    task automatic test_repeat_rate();
        logic       exp_step;
        logic       accel;
        int         ep = 0;
        logic [N-1:0] er;
`ifdef ROTARY_ACCEL_EN
        accel = 1'b1;
`else
        accel = 1'b0;
`endif
        reset = 1'b1; cyc(); reset = 1'b0;
        io.cw = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            exp_step = (i == 0) || (i == 10) || (i == 14) || (i == 18) ||
                       (i > 18 && (accel || ((i - 18) % 4) == 0));
            if (exp_step) ep = (ep == 0) ? N - 1 : ep - 1;
            n_tests++; if (io.step !== exp_step) begin
                n_fail++; $display("FAIL rate_step c%0d: got %b expected %b", i, io.step, exp_step);
            end
        end
        io.cw = 1'b0;
        cyc();
        er = {{(N-1){1'b0}}, 1'b1} << ep;
        n_tests++; if (io.pos !== 4'(ep) || io.rotary !== er) begin
            n_fail++; $display("FAIL rate_final: got pos=%0d rotary=%h expected pos=%0d rotary=%h", io.pos, io.rotary, ep, er);
        end
    endtask

    initial begin
        io.cw  = 1'b0;
        io.ccw = 1'b0;
        test_reset();
        test_single_cw();
        test_ccw_pulse();
        test_hold_repeat();
        test_both_pressed();
        test_dir_change();
        test_reset_mid_hold();
        test_repeat_rate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
